// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the hazard controller and the mult/div sequencer.
package hazard_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Order matches the execute-stage mux3 inputs.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 32;
  localparam int DEF_CNT_W      = 6;

  // A source can take a younger result only if it is a real (non-$0) register being written.
  function automatic logic regMatch(input logic [4:0] src, input logic we, input logic [4:0] dst);
    return we && (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic hitsSrc(input logic [4:0] dst, input logic [4:0] srcA, input logic [4:0] srcB);
    return (dst != 5'd0) && ((dst == srcA) || (dst == srcB));
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Busy-window sequencer for the shared iterative multiply/divide unit.
module muldiv_seq
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdstartE,
  input  logic mdopE,
  output logic mdbusy,
  output logic mddone,
  output logic idle
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]       stateReg, stateNext;
  logic [CNT_W-1:0] countReg, countNext;

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    if (stateReg == IDLE) begin
      if (mdstartE) begin
        stateNext = BUSY;
        countNext = mdopE ? DIV_LOAD : MUL_LOAD;
      end
    end else if (countReg == '0) begin
      stateNext = IDLE;
    end else begin
      countNext = countReg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      countReg <= '0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
    end
  end

  assign idle   = (stateReg == IDLE);
  assign mdbusy = (stateReg == BUSY);
  assign mddone = (stateReg == BUSY) && (countReg == '0);

endmodule

// File: rtl/hazard_sched.sv
// Forwarding selects, stall/flush generation and mult/div scheduling for the 5-stage core.
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       mdstartE,
  input  logic       mdopE,
  input  logic       hiloD,
  output logic [1:0] forwardaE,
  output logic [1:0] forwardbE,
  output logic       forwardaD,
  output logic       forwardbD,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       flushM,
  output logic       mdbusy,
  output logic       mddone
);

  logic [1:0][4:0] srcE, srcD;
  logic [1:0][1:0] fwdE;
  logic [1:0]      fwdD;

  assign srcE = {rtE, rsE};
  assign srcD = {rtD, rsD};

  // Index 0 is the rs operand, index 1 the rt operand; M wins over W.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwdE[gi] = regMatch(srcE[gi], regwriteM, writeregM) ? FWD_MEM :
                      regMatch(srcE[gi], regwriteW, writeregW) ? FWD_WB  : FWD_RF;
    assign fwdD[gi] = regMatch(srcD[gi], regwriteM, writeregM);
  end

  logic seqBusy, seqDone, seqIdle;

  muldiv_seq #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_muldiv_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .mdstartE(mdstartE),
    .mdopE   (mdopE),
    .mdbusy  (seqBusy),
    .mddone  (seqDone),
    .idle    (seqIdle)
  );

  logic lwStall, brStall, hiloStall, mdConflict, frontStall;

  assign lwStall    = memtoregE && hitsSrc(rtE, rsD, rtD);
  assign brStall    = branchD && ((regwriteE && hitsSrc(writeregE, rsD, rtD)) ||
                                  (memtoregM && hitsSrc(writeregM, rsD, rtD)));
  assign hiloStall  = hiloD && seqBusy;
  assign mdConflict = mdstartE && !seqIdle;
  assign frontStall = lwStall || brStall || hiloStall;

  // Everything is held at zero while reset is asserted, independent of the clock.
  assign forwardaE = rst_n ? fwdE[0] : FWD_RF;
  assign forwardbE = rst_n ? fwdE[1] : FWD_RF;
  assign forwardaD = rst_n && fwdD[0];
  assign forwardbD = rst_n && fwdD[1];
  assign stallE    = rst_n && mdConflict;
  assign stallF    = rst_n && (frontStall || mdConflict);
  assign stallD    = rst_n && (frontStall || mdConflict);
  assign flushE    = rst_n && frontStall && !mdConflict;
  assign flushM    = rst_n && mdConflict;
  assign mdbusy    = rst_n && seqBusy;
  assign mddone    = rst_n && seqDone;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: forwarding, load-use/branch stalls and mult/div scheduling.
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, mdstartE, mdopE, hiloD;
  logic [1:0] forwardaE, forwardbE;
  logic       forwardaD, forwardbD, stallF, stallD, stallE, flushE, flushM, mdbusy, mddone;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  hazard_sched dut (
    .clk(clk), .rst_n(rst_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .mdstartE(mdstartE), .mdopE(mdopE), .hiloD(hiloD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .flushM(flushM),
    .mdbusy(mdbusy), .mddone(mddone)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0;
    branchD = 0; mdstartE = 0; mdopE = 0; hiloD = 0;
  endtask

  function automatic logic [31:0] allOutputs();
    return {forwardaE, forwardbE, forwardaD, forwardbD, stallF, stallD, stallE,
            flushE, flushM, mdbusy, mddone};
  endfunction

  int busyCnt, doneCnt, doneAt;

  initial begin
    clearInputs();
    rst_n = 1'b0;
    // Hazard-provoking inputs during reset must not leak to the outputs.
    regwriteM = 1; writeregM = 5; rsE = 5; rtE = 5; rsD = 5;
    memtoregE = 1; mdstartE = 1; hiloD = 1;
    #1;
    checkEq("reset_outputs_comb", allOutputs(), 32'h0);
    tick();
    tick();
    checkEq("reset_outputs_clocked", allOutputs(), 32'h0);
    clearInputs();
    rst_n = 1'b1;
    #1;
    checkEq("post_reset_idle", {30'b0, mdbusy, mddone}, 32'h0);

    // Forwarding priority
    regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5; rsE = 5; #1;
    checkEq("fwdA_mem_priority", forwardaE, 2'b10);
    regwriteM = 0; #1;
    checkEq("fwdA_wb", forwardaE, 2'b01);
    rsE = 0; #1;
    checkEq("fwdA_rsE_zero", forwardaE, 2'b00);
    rtE = 5; regwriteM = 1; writeregM = 7; #1;
    checkEq("fwdB_wb_no_mem_hit", forwardbE, 2'b01);
    writeregM = 0; writeregW = 0; rtE = 0; #1;
    checkEq("fwdB_reg0", forwardbE, 2'b00);
    rsD = 6; rtD = 9; writeregM = 9; #1;
    checkEq("fwdD_pair", {forwardaD, forwardbD}, 2'b01);
    regwriteM = 0; #1;
    checkEq("fwdD_no_write", {forwardaD, forwardbD}, 2'b00);
    clearInputs();

    // Load-use: one stall cycle, then the bubble clears it
    tick();
    memtoregE = 1; rtE = 8; rsD = 8; #1;
    checkEq("lw_stall_flags", {stallF, stallD, flushE, stallE}, 4'b1110);
    tick();
    memtoregE = 0; rtE = 0; #1;
    checkEq("lw_stall_released", {stallF, stallD, flushE}, 3'b000);
    memtoregE = 1; rtE = 0; rsD = 0; rtD = 0; #1;
    checkEq("lw_reg0_no_stall", {stallF, stallD, flushE}, 3'b000);
    clearInputs();

    // Branch compare hazards
    branchD = 1; regwriteE = 1; writeregE = 9; rsD = 9; #1;
    checkEq("br_alu_in_E", {stallD, flushE}, 2'b11);
    regwriteE = 0; memtoregM = 1; writeregM = 9; rsD = 3; rtD = 9; #1;
    checkEq("br_load_in_M", {stallD, flushE}, 2'b11);
    branchD = 0; #1;
    checkEq("no_branch_no_stall", {stallD, flushE}, 2'b00);
    clearInputs();

    // Divide window: start accepted this cycle (t)
    tick();
    mdstartE = 1; mdopE = 1; #1;
    checkEq("div_start_not_busy", {mdbusy, stallE}, 2'b00);
    tick();
    mdstartE = 0; mdopE = 0;
    busyCnt = 0; doneCnt = 0; doneAt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (mdbusy) busyCnt++;
      if (mddone) begin doneCnt++; doneAt = i; end
      tick();
    end
    checkEq("div_busy_cycles", busyCnt, 32);
    checkEq("div_done_count", doneCnt, 1);
    checkEq("div_done_at", doneAt, 32);
    checkEq("div_idle_after", mdbusy, 1'b0);

    // HI/LO wait behind a mult started at t
    mdstartE = 1; mdopE = 0;
    tick();                       // t+1
    mdstartE = 0;
    tick();                       // t+2
    hiloD = 1; #1;
    checkEq("hilo_stall_t2", {stallD, stallF, flushE, mddone}, 4'b1110);
    tick();                       // t+3
    checkEq("hilo_stall_t3", {stallD, mddone}, 2'b10);
    tick();                       // t+4, done cycle still stalls
    checkEq("hilo_stall_done", {stallD, mddone}, 2'b11);
    tick();                       // t+5
    checkEq("hilo_released", {stallD, mdbusy}, 2'b00);
    hiloD = 0;

    // Back-to-back mult: second start held until IDLE
    mdstartE = 1; mdopE = 0;
    tick();                       // t+1
    mdstartE = 1; #1;             // second mult reaches E while busy
    checkEq("b2b_hold_t1", {stallE, flushM, stallD, flushE}, 4'b1110);
    tick();                       // t+2
    memtoregE = 1; rtE = 8; rsD = 8; #1;
    checkEq("b2b_hold_with_lw", {stallE, flushE, stallD}, 3'b101);
    memtoregE = 0; rtE = 0; rsD = 0;
    tick();                       // t+3
    tick();                       // t+4, done cycle: still held
    checkEq("b2b_hold_done", {stallE, flushM, mddone}, 3'b111);
    tick();                       // t+5, IDLE: accepted
    checkEq("b2b_accept", {stallE, flushM, mdbusy}, 3'b000);
    tick();
    mdstartE = 0;
    busyCnt = 0; doneCnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (mdbusy) busyCnt++;
      if (mddone) doneCnt++;
      tick();
    end
    checkEq("b2b_busy_cycles", busyCnt, 4);
    checkEq("b2b_done_count", doneCnt, 1);

    // Reset during a divide
    mdstartE = 1; mdopE = 1;
    tick();
    mdstartE = 0;
    for (int i = 1; i < 7; i++) tick();
    checkEq("rst_mid_busy_before", mdbusy, 1'b1);
    rst_n = 0; hiloD = 1; #1;
    checkEq("rst_mid_outputs", allOutputs(), 32'h0);
    tick();
    rst_n = 1; hiloD = 0; #1;
    checkEq("rst_mid_fsm_idle", mdbusy, 1'b0);
    doneCnt = 0; busyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (mddone) doneCnt++;
      if (mdbusy) busyCnt++;
      tick();
    end
    checkEq("rst_mid_no_done", doneCnt, 0);
    checkEq("rst_mid_no_busy", busyCnt, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
